// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencer producing data/parity bits and 4:1 line-mux selects
// Optional parity state enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_start,
    input  logic [7:0] Tx_data,
    output logic       Tx_busy,
    output logic       Tx_done,
    output logic       Data_Bit,
    output logic       Parity_Bit,
    output logic       S0,
    output logic       S1
);

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_q;
    logic        bit_end;

    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign Data_Bit   = shift_reg[0];
    assign Parity_Bit = parity_q;

    // Selects and status decode purely from the registered state so the line never glitches.
    always_comb begin
        state_nxt = state;
        {S0, S1}  = 2'b11;
        Tx_busy   = 1'b1;
        Tx_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                Tx_busy = 1'b0;
                if (Tx_start) state_nxt = ST_START;
            end
            ST_START: begin
                {S0, S1} = 2'b00;
                if (bit_end) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                {S0, S1} = 2'b01;
                if (bit_end && (bit_cnt == 3'd7)) state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                {S0, S1} = 2'b10;
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                Tx_done = bit_end;
                if (bit_end) state_nxt = ST_IDLE;
            end
            default: begin
                Tx_busy   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every state entry coincides with bit_end or leaving IDLE, so both clear the baud counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (state == ST_DATA) begin
                if (bit_end) begin
                    bit_cnt   <= bit_cnt + 3'd1;
                    shift_reg <= {1'b0, shift_reg[7:1]};
                end
            end else begin
                bit_cnt <= '0;
                if ((state == ST_IDLE) && Tx_start) begin
                    shift_reg <= Tx_data;
                    parity_q  <= PARITY_EN & ((^Tx_data) ^ PARITY_ODD);
                end
            end
        end
    end

endmodule
